// File: rtl/trace_checker.sv
// Commit-trace checker: compares register-file writes against a preloaded expected trace,
// detects branch-to-self halt and a cycle budget, and holds a sticky pass/fail verdict.
module trace_checker #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int MAX_CYCLES = 1024,
    parameter int CW         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] pc,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW:0]     exp_count,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [2:0]      err_code,
    output logic [AW:0]     err_idx,
    output logic [CW-1:0]   cycle_cnt,
    output logic [CW-1:0]   retire_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0]    E_NONE    = 3'd0;
    localparam logic [2:0]    E_DATA    = 3'd1;
    localparam logic [2:0]    E_RD      = 3'd2;
    localparam logic [2:0]    E_EXTRA   = 3'd3;
    localparam logic [2:0]    E_MISSING = 3'd4;
    localparam logic [2:0]    E_TIMEOUT = 3'd5;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CYC  = CW'(MAX_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [AW:0] clamp_count(input logic [AW:0] v);
        return (v > DEPTH_C) ? DEPTH_C : v;
    endfunction

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    state_t          state_q;
    logic            busy_q, done_q, pass_q, fail_q;
    logic [2:0]      err_code_q;
    logic [AW:0]     err_idx_q;
    logic [CW-1:0]   cycle_q, retire_q;
    logic [AW:0]     wp_q, exp_cnt_q;
    logic [XLEN-1:0] prev_pc_q;
    logic            prev_valid_q;

    logic            wr_act, halt, hit_d, halt_hit_d;
    logic [2:0]      code_d;
    logic [AW:0]     wp_d;

    // Trace memory has no reset so a loaded trace survives rst and re-runs.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && ld_we) begin
            mem_rd[ld_addr]   <= ld_rd;
            mem_data[ld_addr] <= ld_data;
        end
    end

    // A clean write advances wp before halt is judged, so a final write on the halt cycle counts.
    always_comb begin
        wr_act     = rf_we && (rf_waddr != 5'd0);
        halt       = prev_valid_q && (pc == prev_pc_q);
        hit_d      = 1'b0;
        halt_hit_d = 1'b0;
        code_d     = E_NONE;
        wp_d       = wp_q;
        if (wr_act && wp_q == exp_cnt_q) begin
            hit_d  = 1'b1;
            code_d = E_EXTRA;
        end else if (wr_act && rf_waddr != mem_rd[wp_q[AW-1:0]]) begin
            hit_d  = 1'b1;
            code_d = E_RD;
        end else if (wr_act && rf_wdata != mem_data[wp_q[AW-1:0]]) begin
            hit_d  = 1'b1;
            code_d = E_DATA;
        end else begin
            if (wr_act) wp_d = wp_q + 1'b1;
            if (halt) begin
                hit_d      = 1'b1;
                halt_hit_d = 1'b1;
                code_d     = (wp_d == exp_cnt_q) ? E_NONE : E_MISSING;
            end else if (cycle_q == LAST_CYC) begin
                hit_d  = 1'b1;
                code_d = E_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_code_q   <= E_NONE;
            err_idx_q    <= '0;
            cycle_q      <= '0;
            retire_q     <= '0;
            wp_q         <= '0;
            exp_cnt_q    <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        err_code_q   <= E_NONE;
                        err_idx_q    <= '0;
                        cycle_q      <= '0;
                        retire_q     <= '0;
                        wp_q         <= '0;
                        prev_valid_q <= 1'b0;
                        exp_cnt_q    <= clamp_count(exp_count);
                    end
                end
                S_RUN: begin
                    if (hit_d) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= (code_d == E_NONE);
                        fail_q     <= (code_d != E_NONE);
                        err_code_q <= code_d;
                        err_idx_q  <= wp_d;
                        wp_q       <= wp_d;
                        if (halt_hit_d) cycle_q <= sat_inc(cycle_q);
                    end else begin
                        wp_q         <= wp_d;
                        cycle_q      <= sat_inc(cycle_q);
                        retire_q     <= sat_inc(retire_q);
                        prev_pc_q    <= pc;
                        prev_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign err_code   = err_code_q;
    assign err_idx    = err_idx_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: each run pushes its expected verdict, popped when done rises.
module tb_trace_checker;

    localparam int XLEN = 32, DEPTH = 8, AW = 3, MAXC = 16, CW = 16;

    logic            clk = 1'b0;
    logic            rst, start, rf_we, ld_we;
    logic [XLEN-1:0] pc, rf_wdata, ld_data;
    logic [4:0]      rf_waddr, ld_rd;
    logic [AW-1:0]   ld_addr;
    logic [AW:0]     exp_count;
    logic            busy, done, pass, fail;
    logic [2:0]      err_code;
    logic [AW:0]     err_idx;
    logic [CW-1:0]   cycle_cnt, retire_cnt;

    trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .MAX_CYCLES(MAXC), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ld_we(ld_we), .ld_addr(ld_addr), .ld_rd(ld_rd), .ld_data(ld_data),
        .exp_count(exp_count), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_code(err_code), .err_idx(err_idx), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] dat;
    } step_t;

    typedef struct {
        string       tag;
        logic        pass;
        logic        fail;
        logic [2:0]  code;
        logic [3:0]  idx;
        int          cyc;
        int          ret;
        int          lat;
    } exp_t;

    step_t prog[$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [4:0] r, input logic [31:0] d);
        step_t s;
        s.pc = a; s.we = w; s.rd = r; s.dat = d;
        prog.push_back(s);
    endtask

    task automatic load(input int addr, input logic [4:0] r, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = AW'(addr); ld_rd = r; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic load_std();
        load(0, 5'd13, 32'h19);
        load(1, 5'd5,  32'h5);
        load(2, 5'd1,  32'h2);
        load(3, 5'd22, 32'h8);
    endtask

    task automatic prog_std();
        add(32'd0,  1'b1, 5'd13, 32'h19);
        add(32'd4,  1'b1, 5'd5,  32'h5);
        add(32'd8,  1'b1, 5'd1,  32'h2);
        add(32'd12, 1'b1, 5'd22, 32'h8);
        add(32'd16, 1'b0, 5'd0,  32'h0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_fail"}, fail, 0);
        check_eq({tag, "_code"}, err_code, 0);
        check_eq({tag, "_idx"}, err_idx, 0);
        check_eq({tag, "_cyc"}, cycle_cnt, 0);
        check_eq({tag, "_ret"}, retire_cnt, 0);
    endtask

    task automatic drive_step(input int i);
        if (i < prog.size()) begin
            pc = prog[i].pc; rf_we = prog[i].we; rf_waddr = prog[i].rd; rf_wdata = prog[i].dat;
        end else begin
            pc = prog[prog.size()-1].pc; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = '0;
        end
    endtask

    task automatic run(input string tag, input logic p, input logic f, input logic [2:0] c,
                       input logic [3:0] idx, input int cyc, input int ret, input int lat,
                       input int cnt, input bit ld_noise, input int start_at);
        exp_t e, got_e;
        bit   got;
        int   n;
        e.tag = tag; e.pass = p; e.fail = f; e.code = c; e.idx = idx;
        e.cyc = cyc; e.ret = ret; e.lat = lat;
        sb.push_back(e);
        exp_count = (AW+1)'(cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_start_busy"}, busy, 1);
        check_eq({tag, "_start_done"}, done, 0);
        check_eq({tag, "_start_code"}, err_code, 0);
        check_eq({tag, "_start_cyc"}, cycle_cnt, 0);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive_step(i);
            ld_we = ld_noise; ld_addr = AW'(i); ld_rd = 5'd31; ld_data = 32'hDEAD;
            start = (i == start_at);
            @(posedge clk); #1;
            n = i + 1;
            if (done) got = 1'b1;
        end
        rf_we = 1'b0; ld_we = 1'b0; start = 1'b0;
        got_e = sb.pop_front();
        if (!got) begin
            check_eq({got_e.tag, "_verdict_wait"}, 0, 1);
        end else begin
            check_eq({got_e.tag, "_pass"}, pass, got_e.pass);
            check_eq({got_e.tag, "_fail"}, fail, got_e.fail);
            check_eq({got_e.tag, "_code"}, err_code, got_e.code);
            check_eq({got_e.tag, "_idx"}, err_idx, got_e.idx);
            check_eq({got_e.tag, "_cyc"}, cycle_cnt, got_e.cyc);
            check_eq({got_e.tag, "_ret"}, retire_cnt, got_e.ret);
            check_eq({got_e.tag, "_busy"}, busy, 0);
            check_eq({got_e.tag, "_lat"}, n, got_e.lat);
        end
        prog.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        ld_we = 1'b0; ld_addr = '0; ld_rd = '0; ld_data = '0; exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        load_std();

        prog_std();
        run("pass", 1, 0, 0, 4, 6, 5, 6, 4, 0, -1);

        // Verdict must hold in DONE while the core keeps going.
        pc = 32'h100; rf_we = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        rf_we = 1'b0;
        check_eq("hold_done", done, 1);
        check_eq("hold_pass", pass, 1);
        check_eq("hold_ret", retire_cnt, 5);

        add(32'd0, 1, 13, 32'h19); add(32'd4, 1, 5, 32'h5); add(32'd8, 1, 1, 32'h2);
        add(32'd12, 0, 0, 0); add(32'd12, 1, 22, 32'h8);
        run("halt_write", 1, 0, 0, 4, 5, 4, 5, 4, 0, -1);

        add(32'd0, 1, 13, 32'h19); add(32'd4, 1, 5, 32'h5); add(32'd8, 1, 1, 32'h3);
        run("data_mis", 0, 1, 1, 2, 2, 2, 3, 4, 0, -1);

        add(32'd0, 1, 13, 32'h19); add(32'd4, 1, 5, 32'h5); add(32'd8, 1, 4, 32'h2);
        run("rd_mis", 0, 1, 2, 2, 2, 2, 3, 4, 0, -1);

        prog_std();
        prog[4].we = 1'b1; prog[4].rd = 5'd7; prog[4].dat = 32'h1;
        run("extra", 0, 1, 3, 4, 4, 4, 5, 4, 0, -1);

        add(32'd0, 1, 13, 32'h19); add(32'd4, 1, 5, 32'h5); add(32'd8, 1, 1, 32'h2);
        add(32'd12, 0, 0, 0);
        run("missing", 0, 1, 4, 3, 5, 4, 5, 4, 0, -1);

        add(32'd0, 1, 0, 32'h99); add(32'd4, 1, 13, 32'h19); add(32'd8, 1, 0, 32'h7);
        add(32'd12, 1, 5, 32'h5); add(32'd16, 1, 1, 32'h2); add(32'd20, 1, 22, 32'h8);
        add(32'd24, 1, 0, 32'h1); add(32'd24, 1, 0, 32'h3);
        run("x0_writes", 1, 0, 0, 4, 8, 7, 8, 4, 0, -1);

        for (int k = 0; k < 20; k++) add(32'(k * 4), 1'b0, 5'd0, 32'h0);
        run("timeout", 0, 1, 5, 0, 15, 15, 16, 4, 0, -1);

        add(32'd0, 1, 13, 32'h19);
        run("cnt_zero", 0, 1, 3, 0, 0, 0, 1, 0, 0, -1);

        prog_std();
        run("start_in_run", 1, 0, 0, 4, 6, 5, 6, 4, 0, 2);

        prog_std();
        run("ld_in_run", 1, 0, 0, 4, 6, 5, 6, 4, 1, -1);

        // Abort a run with rst, then a fresh run against the same trace.
        exp_count = 4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4); rf_we = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        prog_std();
        run("after_rst", 1, 0, 0, 4, 6, 5, 6, 4, 0, -1);

        // Full-depth trace with an oversized count that must clamp to DEPTH.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) load(k, 5'(k + 1), 32'(k * 3 + 1));
        for (int k = 0; k < DEPTH; k++) add(32'(k * 4), 1'b1, 5'(k + 1), 32'(k * 3 + 1));
        add(32'd32, 1'b0, 5'd0, 32'h0);
        run("clamp", 1, 0, 0, 8, 10, 9, 10, 12, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
